// File: rtl/serial_pkg.sv
// Shared defaults and the loader state encoding for the serial frame path
// (receiver, line buffer, frame RAM and RAM loader).
package serial_pkg;

    localparam int         DEF_WIDTH     = 8;
    localparam int         DEF_BUF_SIZE  = 80;
    localparam int         DEF_ADDR_W    = 9;
    localparam int         DEF_LINES     = 320;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int         DEF_TIMEOUT   = 100000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } load_state_t;

endpackage

// File: rtl/ram_load_ctrl_line_packer.sv
// Line register with byte lane counter; line_full is the line as it will look
// once the byte currently offered is accepted.
module line_packer #(
    parameter int WIDTH    = 8,
    parameter int BUF_SIZE = 80
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      accept,
    input  logic [WIDTH-1:0]          data,
    output logic [BUF_SIZE*WIDTH-1:0] line_full,
    output logic                      line_done
);

    localparam int BCW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;

    logic [BCW-1:0]            byte_cnt;
    logic [BUF_SIZE*WIDTH-1:0] line;
    logic                      at_last;

    assign at_last   = (byte_cnt == BCW'(BUF_SIZE - 1));
    assign line_done = accept && at_last;

    always_comb begin
        line_full = line;
        line_full[int'(byte_cnt)*WIDTH +: WIDTH] = data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            line     <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
            line     <= '0;
        end else if (accept) begin
            line     <= line_full;
            byte_cnt <= at_last ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_load_ctrl.sv
// Frame loader: waits for the sync byte, packs bytes into RAM lines, writes one
// line per WRITE cycle, then hands the RAM address port to the SAD datapath.
//
// state | meaning
// IDLE  | discard bytes until the sync byte arrives
// FILL  | pack received bytes into the current line
// WRITE | one-cycle RAM write of the completed line
// DONE  | frame stored; datapath may own the RAM address port
module ram_load_ctrl
    import serial_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               BUF_SIZE  = DEF_BUF_SIZE,
    parameter int               ADDR_W    = DEF_ADDR_W,
    parameter int               LINES     = DEF_LINES,
    parameter logic [WIDTH-1:0] SYNC_BYTE = WIDTH'(DEF_SYNC_BYTE),
    parameter int               TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_valid,
    input  logic [WIDTH-1:0]          rx_data,
    input  logic                      clear,
    input  logic                      proc_req,
    input  logic [ADDR_W-1:0]         proc_addr,
    output logic                      proc_grant,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [BUF_SIZE*WIDTH-1:0] ram_wdata,
    output logic                      load_done,
    output logic                      frame_err
);

    localparam int                TW        = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(LINES - 1);
    localparam logic [TW-1:0]     TMO_LOAD  = TW'(TIMEOUT);

    load_state_t               state;
    load_state_t               state_next;
    logic [ADDR_W-1:0]         line_cnt;
    logic [TW-1:0]             tmo_cnt;
    logic                      in_frame;
    logic                      last_line;
    logic                      start;
    logic                      timeout;
    logic                      accept;
    logic                      line_done;
    logic                      packer_clr;
    logic [BUF_SIZE*WIDTH-1:0] line_full;

    assign in_frame   = (state == FILL) || (state == WRITE);
    assign last_line  = (line_cnt == LAST_LINE);
    assign start      = (state == IDLE) && rx_valid && (rx_data == SYNC_BYTE) && !clear;
    // The final write always completes; a timeout there would only discard a full frame.
    assign timeout    = in_frame && !rx_valid && (tmo_cnt == TW'(1))
                        && !((state == WRITE) && last_line);
    assign accept     = rx_valid && !clear
                        && ((state == FILL) || ((state == WRITE) && !last_line));
    assign packer_clr = clear || start || timeout;

    line_packer #(
        .WIDTH    (WIDTH),
        .BUF_SIZE (BUF_SIZE)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (packer_clr),
        .accept    (accept),
        .data      (rx_data),
        .line_full (line_full),
        .line_done (line_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = FILL;
                FILL: begin
                    if (timeout)        state_next = IDLE;
                    else if (line_done) state_next = WRITE;
                end
                WRITE: begin
                    if (timeout)        state_next = IDLE;
                    else if (last_line) state_next = DONE;
                    else                state_next = FILL;
                end
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ram_we    = (state == WRITE);
        load_done = (state == DONE);
        ram_addr  = line_cnt;
        if ((state == DONE) && proc_grant) ram_addr = proc_addr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_cnt <= '0;
        end else if (clear || timeout || start) begin
            line_cnt <= '0;
        end else if ((state == WRITE) && !last_line) begin
            line_cnt <= line_cnt + 1'b1;
        end
    end

    // Idle-cycle timer counts down from TIMEOUT; any byte in the frame reloads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (clear || timeout) begin
            tmo_cnt <= '0;
        end else if (start) begin
            tmo_cnt <= TMO_LOAD;
        end else if (in_frame) begin
            if (rx_valid)           tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_wdata  <= '0;
            frame_err  <= 1'b0;
            proc_grant <= 1'b0;
        end else begin
            frame_err  <= timeout && !clear;
            proc_grant <= (state == DONE) && proc_req && !clear;
            if (clear)          ram_wdata <= '0;
            else if (line_done) ram_wdata <= line_full;
        end
    end

endmodule

// File: tb/tb_ram_load_ctrl.sv
// Directed bench for ram_load_ctrl with 4-byte lines, 3-line frames and a
// 50-cycle inter-byte timeout.
module tb_ram_load_ctrl;

    localparam int WIDTH    = 8;
    localparam int BUF_SIZE = 4;
    localparam int ADDR_W   = 9;
    localparam int LINES    = 3;
    localparam int TIMEOUT  = 50;

    logic                      clk;
    logic                      rst;
    logic                      rx_valid;
    logic [WIDTH-1:0]          rx_data;
    logic                      clear;
    logic                      proc_req;
    logic [ADDR_W-1:0]         proc_addr;
    logic                      proc_grant;
    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [BUF_SIZE*WIDTH-1:0] ram_wdata;
    logic                      load_done;
    logic                      frame_err;

    ram_load_ctrl #(
        .WIDTH     (WIDTH),
        .BUF_SIZE  (BUF_SIZE),
        .ADDR_W    (ADDR_W),
        .LINES     (LINES),
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .clear      (clear),
        .proc_req   (proc_req),
        .proc_addr  (proc_addr),
        .proc_grant (proc_grant),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .load_done  (load_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int err_cnt = 0;
    int err_snap;
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    logic [31:0]       exp_line[3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};

    // Write and error logger, sampled mid-cycle
    always @(negedge clk) begin
        if (ram_we) begin
            wa_q.push_back(ram_addr);
            wd_q.push_back(ram_wdata);
        end
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic send_frame(input int gap);
        drive_byte(8'hA5);
        for (int b = 1; b <= 12; b++) begin
            drive_byte(8'(b));
            idle(gap);
        end
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_nwrites"}, 64'(wa_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_addr"}, (i < wa_q.size()) ? 64'(wa_q[i]) : '1, 64'(i));
            check({tag, "_data"}, (i < wd_q.size()) ? 64'(wd_q[i]) : '1, 64'(exp_line[i]));
        end
    endtask

    initial begin
        rst       = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        clear     = 1'b0;
        proc_req  = 1'b0;
        proc_addr = '0;
        idle(3);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_done", load_done, 0);
        check("rst_grant", proc_grant, 0);
        check("rst_err", frame_err, 0);
        rst = 1'b1;
        step();

        // Back-to-back frame; byte 05 arrives during the line-0 write
        clear_log();
        drive_byte(8'hA5);
        for (int b = 1; b <= 4; b++) drive_byte(8'(b));
        check("we_line0", ram_we, 1);
        check("addr_line0", ram_addr, 0);
        check("wdata_line0", ram_wdata, 32'h04030201);
        for (int b = 5; b <= 12; b++) drive_byte(8'(b));
        check("we_line2", ram_we, 1);
        check("done_early", load_done, 0);
        step();
        check("load_done", load_done, 1);
        check("we_after", ram_we, 0);
        check_frame("normal");

        // Arbitration in DONE
        proc_addr = 9'd2;
        proc_req  = 1'b1;
        #1;
        check("grant_lag", proc_grant, 0);
        step();
        check("grant_on", proc_grant, 1);
        check("grant_addr2", ram_addr, 2);
        proc_addr = 9'd1;
        #1;
        check("grant_addr1", ram_addr, 1);
        proc_req = 1'b0;
        step();
        check("grant_off", proc_grant, 0);
        check("addr_loader", ram_addr, 2);

        clear_log();
        drive_byte(8'hA5);
        drive_byte(8'h01);
        check("done_hold", load_done, 1);
        check("done_no_wr", 64'(wa_q.size()), 0);

        // Clear in DONE
        proc_req = 1'b1;
        step();
        check("grant_pre_clr", proc_grant, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_done", load_done, 0);
        check("clr_grant", proc_grant, 0);
        check("clr_err", frame_err, 0);
        step();
        check("idle_grant", proc_grant, 0);
        proc_req = 1'b0;

        // Clear beats a coincident sync byte
        clear_log();
        clear = 1'b1;
        drive_byte(8'hA5);
        clear = 1'b0;
        for (int b = 1; b <= 4; b++) drive_byte(8'(b));
        step();
        check("clr_sync_no_wr", 64'(wa_q.size()), 0);

        // Pre-sync noise, gapped frame, request held during load
        clear_log();
        drive_byte(8'h00);
        drive_byte(8'hFF);
        drive_byte(8'h5A);
        check("noise_no_wr", 64'(wa_q.size()), 0);
        proc_req  = 1'b1;
        proc_addr = 9'd3;
        drive_byte(8'hA5);
        for (int b = 1; b <= 12; b++) begin
            drive_byte(8'(b));
            idle(2);
            if (b == 6) begin
                check("load_grant", proc_grant, 0);
                check("load_addr", ram_addr, 1);
            end
        end
        check("noise_done", load_done, 1);
        check("noise_grant", proc_grant, 1);
        check_frame("noise");
        proc_req = 1'b0;
        clear    = 1'b1;
        step();
        clear = 1'b0;

        // Timeout mid-frame
        clear_log();
        err_cnt = 0;
        drive_byte(8'hA5);
        for (int b = 1; b <= 6; b++) drive_byte(8'(b));
        idle(49);
        check("tmo_early_err", frame_err, 0);
        check("tmo_early_cnt", 64'(err_cnt), 0);
        step();
        check("tmo_err", frame_err, 1);
        step();
        check("tmo_err_pulse", frame_err, 0);
        check("tmo_err_cnt", 64'(err_cnt), 1);
        check("tmo_done", load_done, 0);
        check("tmo_nwrites", 64'(wa_q.size()), 1);
        check("tmo_addr", (wa_q.size() > 0) ? 64'(wa_q[0]) : '1, 0);
        check("tmo_data", (wd_q.size() > 0) ? 64'(wd_q[0]) : '1, 32'h04030201);
        for (int b = 1; b <= 4; b++) drive_byte(8'(b));
        step();
        check("tmo_idle", 64'(wa_q.size()), 1);

        clear_log();
        send_frame(0);
        step();
        check("retry_done", load_done, 1);
        check_frame("retry");
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Byte on the terminal-count cycle is accepted
        clear_log();
        err_cnt = 0;
        drive_byte(8'hA5);
        drive_byte(8'h01);
        idle(49);
        drive_byte(8'h02);
        check("tc_err", frame_err, 0);
        idle(49);
        drive_byte(8'h03);
        drive_byte(8'h04);
        check("tc_err_cnt", 64'(err_cnt), 0);
        check("tc_we", ram_we, 1);
        check("tc_wdata", ram_wdata, 32'h04030201);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Reset mid-line
        clear_log();
        drive_byte(8'hA5);
        for (int b = 1; b <= 6; b++) drive_byte(8'(b));
        err_snap = err_cnt;
        rst = 1'b0;
        #1;
        check("mrst_we", ram_we, 0);
        check("mrst_addr", ram_addr, 0);
        check("mrst_wdata", ram_wdata, 0);
        check("mrst_done", load_done, 0);
        check("mrst_grant", proc_grant, 0);
        check("mrst_err", frame_err, 0);
        rst = 1'b1;
        idle(5);
        drive_byte(8'h07);
        drive_byte(8'h08);
        idle(3);
        check("mrst_nwrites", 64'(wa_q.size()), 1);
        check("mrst_no_err", 64'(err_cnt), 64'(err_snap));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_load_ctrl.md
# ram_load_ctrl

Sequencer between the UART byte receiver and the line-wide frame RAM of the SAD processor. It waits for a sync byte, packs `BUF_SIZE` received bytes per RAM line, and issues one write per line at incrementing addresses until `LINES` lines are stored. It then hands the RAM address port to the SAD datapath. Inter-byte timeouts abort a partial frame.

## Interface
- `WIDTH`, 8, byte width
- `BUF_SIZE`, 80, bytes per RAM line
- `ADDR_W`, 9, RAM address width
- `LINES`, 320, lines per frame (≤ 2^ADDR_W)
- `SYNC_BYTE`, 8'hA5, frame start marker
- `TIMEOUT`, 100000, max idle cycles between bytes inside a frame
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-low reset
- `rx_valid`  in  1  one-cycle strobe: `rx_data` valid
- `rx_data`  in  WIDTH  received byte
- `clear`  in  1  abort or release; return to IDLE
- `proc_req`  in  1  datapath requests RAM port
- `proc_addr`  in  ADDR_W  datapath read address
- `proc_grant`  out  1  datapath owns RAM port
- `ram_we`  out  1  RAM write strobe
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wdata`  out  BUF_SIZE*WIDTH  packed line
- `load_done`  out  1  full frame stored
- `frame_err`  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE: bytes other than `SYNC_BYTE` are discarded. An `SYNC_BYTE` byte moves the block to FILL and clears the byte counter, line counter and timeout counter. The sync byte itself is not stored.
- FILL: each `rx_valid` byte goes into lane `byte_cnt` of the line register. Lane 0 is bits [WIDTH-1:0]. Then `byte_cnt` increments.
- On accepting byte `BUF_SIZE-1`: `ram_wdata` is loaded with the full line, including that byte; `byte_cnt` is set to 0; the block moves to WRITE.
- WRITE, one cycle: `ram_we`=1 and `ram_addr`=`line_cnt`.
  - If `line_cnt`==`LINES-1`, go to DONE.
  - Otherwise increment `line_cnt` and return to FILL.
  - A byte arriving during WRITE is accepted into lane 0 of the next line and is not lost.
- DONE:
  - `load_done`=1.
  - `proc_grant`=`proc_req`, registered.
  - While granted, `ram_addr`=`proc_addr`, combinational.
  - Bytes received in DONE are ignored.
- `clear`=1 forces IDLE next cycle from any state. `load_done`, `proc_grant`, counters and the line register clear. No `frame_err` is produced.
- Timeout applies in FILL and WRITE only. The counter increments every cycle without `rx_valid` and resets on `rx_valid`. When it reaches `TIMEOUT`:
  - `frame_err` pulses for one cycle and the block goes to IDLE.
  - Lines already written stay in RAM but are invalid, and `load_done` stays 0.
- Outside DONE: `proc_grant`=0, `proc_req` is ignored, and `ram_addr` is driven by the loader (`line_cnt`).
- Counter widths: `byte_cnt` uses clog2(`BUF_SIZE`) bits, `line_cnt` uses `ADDR_W` bits, and `TIMEOUT` uses a counter of clog2(`TIMEOUT`+1) bits. No counter wraps in legal operation.

## Timing
- Reset values: all outputs 0, state IDLE, all counters and registers 0.
- Byte accepted at edge N makes its lane valid after N.
- `ram_we` is registered: it is high in the cycle after the last byte of a line is accepted, for exactly one cycle.
- `load_done` rises in the cycle after the final write pulse.
- `proc_grant` rises one cycle after `proc_req` when in DONE and falls one cycle after `proc_req` drops.
- `clear` takes effect at the next edge. If `clear` and `rx_valid` carrying `SYNC_BYTE` coincide, `clear` wins and the byte is discarded.
- If `rx_valid` coincides with the timeout terminal count, the byte wins: it is accepted and the counter resets.
- Reset asserted mid-frame returns to IDLE immediately, with no write or error pulse. Partially written lines are not rewritten.

## Structure
- Package `serial_pkg`: `WIDTH`, `BUF_SIZE`, `ADDR_W`, `LINES`, `SYNC_BYTE` defaults and the state enum `load_state_t`. Shared with the receiver, buffer and RAM blocks.
- Optional sub-module `line_packer`: line register plus `byte_cnt`, producing a "line complete" strobe. The FSM, line counter, timeout counter and RAM port mux stay in `ram_load_ctrl`.

## Test plan
Bench parameters: `BUF_SIZE`=4, `LINES`=3, `TIMEOUT`=50.

- **Normal frame.** Send A5, then bytes 01..0C.
  - Three `ram_we` pulses at addresses 0, 1, 2 with wdata 04030201, 08070605 and 0C0B0A09.
  - `load_done`=1 the cycle after the third pulse.
- **Pre-sync noise.** Send 00, FF, 5A, then a normal frame. No write occurs before A5, and the frame is stored identically to the normal case.
- **Timeout.** Send A5, 01..06, then idle for 50 cycles.
  - One write at address 0.
  - `frame_err` pulses once, state is IDLE, and `load_done`=0.
  - A following full frame writes again starting at address 0.
- **Back-to-back byte in WRITE.** Send the 5th byte in the same cycle `ram_we` is high for line 0. The line 1 write contains that byte in lane 0.
- **Arbitration.** In DONE, raise `proc_req` with `proc_addr`=2.
  - `proc_grant`=1 one cycle later and `ram_addr`=2.
  - Drop `proc_req`: grant falls in the next cycle.
  - During a load, `proc_req`=1 gives `proc_grant`=0.
- **Clear and reset.** Assert `clear` in DONE: `load_done`=0 and `proc_grant`=0 next cycle. Assert `rst` low mid-line: all outputs 0 immediately, and no `ram_we` follows.
